// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops plus an iterative
// shift-add multiplier and a restoring unsigned divider, behind a
// valid/ready request handshake with a registered, pulsed result.
module alu_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [WIDTH-1:0]  src1_i,
  input  logic [WIDTH-1:0]  src2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              ready_o,
  output logic              out_valid_o,
  output logic [WIDTH-1:0]  result_o,
  output logic              zero_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [CTRL_W-1:0] {
    OP_AND  = CTRL_W'(0),
    OP_OR   = CTRL_W'(1),
    OP_ADD  = CTRL_W'(2),
    OP_MUL  = CTRL_W'(3),
    OP_DIVU = CTRL_W'(4),
    OP_REMU = CTRL_W'(5),
    OP_SUB  = CTRL_W'(6),
    OP_SLT  = CTRL_W'(7),
    OP_SLTU = CTRL_W'(8),
    OP_PASS = CTRL_W'(9),
    OP_NOR  = CTRL_W'(12)
  } op_t;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIVU, K_REMU} kind_t;

  state_t           state;
  kind_t            kind;
  logic [CNT_W-1:0] cnt;
  // op_a: multiplicand (MUL) or dividend shifting into quotient (DIV/REM)
  // op_b: multiplier (MUL) or divisor (DIV/REM)
  // acc : partial product (MUL) or partial remainder (DIV/REM)
  logic [WIDTH-1:0] op_a, op_b, acc;

  logic [WIDTH-1:0] alu_res;
  logic             is_multi;
  kind_t            new_kind;

  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt, q_nxt;
  logic [WIDTH-1:0] a_nxt, b_nxt, acc_nxt, fin_res;

  assign ready_o = (state == IDLE);

  // Single-cycle result and multi-cycle op detection from the live request
  always_comb begin
    alu_res  = '0;
    is_multi = 1'b0;
    new_kind = K_MUL;
    case (ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_NOR:  alu_res = ~(src1_i | src2_i);
      OP_PASS: alu_res = src1_i;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src1_i < src2_i};
      OP_MUL:  begin is_multi = 1'b1; new_kind = K_MUL;  end
      OP_DIVU: begin is_multi = 1'b1; new_kind = K_DIVU; end
      OP_REMU: begin is_multi = 1'b1; new_kind = K_REMU; end
      default: alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum  = acc + (op_b[0] ? op_a : '0);
    rem_sh   = {acc, op_a[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, op_b};
    // partial remainder stays below 2^WIDTH, so the top bit is the borrow;
    // a zero divisor never borrows, giving all-ones quotient and remainder=src1
    div_ge   = ~rem_diff[WIDTH];
    rem_nxt  = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    q_nxt    = {op_a[WIDTH-2:0], div_ge};
    if (kind == K_MUL) begin
      a_nxt   = op_a << 1;
      b_nxt   = op_b >> 1;
      acc_nxt = mul_sum;
      fin_res = mul_sum;
    end else begin
      a_nxt   = q_nxt;
      b_nxt   = op_b;
      acc_nxt = rem_nxt;
      fin_res = (kind == K_DIVU) ? q_nxt : rem_nxt;
    end
  end

  // Handshake FSM, iteration registers and registered result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      kind        <= K_MUL;
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      acc         <= '0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      zero_o      <= 1'b1;
    end else begin
      out_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            if (is_multi) begin
              state <= BUSY;
              kind  <= new_kind;
              cnt   <= CNT_W'(WIDTH);
              op_a  <= src1_i;
              op_b  <= src2_i;
              acc   <= '0;
            end else begin
              result_o    <= alu_res;
              zero_o      <= (alu_res == '0);
              out_valid_o <= 1'b1;
            end
          end
        end
        BUSY: begin
          op_a <= a_nxt;
          op_b <= b_nxt;
          acc  <= acc_nxt;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state       <= IDLE;
            result_o    <= fin_res;
            zero_o      <= (fin_res == '0);
            out_valid_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit and an 8-bit instance share the clock
// and reset; each scenario task drives its own vectors and checks inline.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        v32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [3:0]  c32 = '0;
  logic        rdy32, ov32, z32;
  logic [31:0] r32;

  // 8-bit instance
  logic        v8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  c8 = '0;
  logic        rdy8, ov8, z8;
  logic [7:0]  r8;

  int checks   = 0;
  int failures = 0;
  int pulses32 = 0;
  int pulses8  = 0;

  alu_seq #(.WIDTH(32), .CTRL_W(4)) dut32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v32), .src1_i(a32), .src2_i(b32),
    .ctrl_i(c32), .ready_o(rdy32), .out_valid_o(ov32), .result_o(r32), .zero_o(z32)
  );

  alu_seq #(.WIDTH(8), .CTRL_W(4)) dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v8), .src1_i(a8), .src2_i(b8),
    .ctrl_i(c8), .ready_o(rdy8), .out_valid_o(ov8), .result_o(r8), .zero_o(z8)
  );

  // Count output pulses mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (ov32) pulses32++;
    if (ov8)  pulses8++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multi-cycle op on the 32-bit DUT, keeping in_valid high while
  // busy, and report result, latency (edges from accept) and busy cycles.
  task automatic run32(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic zr, output int lat,
                       output int busy);
    v32 = 1'b1; c32 = c; a32 = a; b32 = b;
    tick();
    // hold a different, valid request during BUSY; it must not be taken
    c32 = 4'd2; a32 = 32'd1; b32 = 32'd1;
    lat = 999; busy = 0; res = '0; zr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (ov32) begin
        lat = k + 1; res = r32; zr = z32;
        break;
      end
      if (!rdy32) busy++;
      tick();
    end
    v32 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (rdy32 !== 1'b1 || ov32 !== 1'b0 || r32 !== 32'd0 || z32 !== 1'b1) begin
      failures++;
      $display("FAIL reset32: rdy=%b ov=%b res=%h zero=%b, want 1 0 0 1", rdy32, ov32, r32, z32);
    end
    checks++;
    if (rdy8 !== 1'b1 || ov8 !== 1'b0 || r8 !== 8'd0 || z8 !== 1'b1) begin
      failures++;
      $display("FAIL reset8: rdy=%b ov=%b res=%h zero=%b, want 1 0 0 1", rdy8, ov8, r8, z8);
    end
    repeat (5) tick();
    checks++;
    if (pulses32 !== 0 || pulses8 !== 0) begin
      failures++;
      $display("FAIL idle_pulse: pulses32=%0d pulses8=%0d, want 0 0", pulses32, pulses8);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  cv [10];
    logic [31:0] av [10], bv [10], ev [10];
    int p0;
    cv = '{4'd2, 4'd6, 4'd7, 4'd8, 4'd6, 4'd0, 4'd1, 4'd12, 4'd9, 4'd10};
    av = '{32'd7, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3,
           32'h0000F0F0, 32'h0000000F, 32'h0, 32'hDEADBEEF, 32'h12345678};
    bv = '{32'd5, 32'd7, 32'd1, 32'd1, 32'd3,
           32'h0000FF00, 32'h000000F0, 32'h0, 32'h11111111, 32'h1};
    ev = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0, 32'd0,
           32'h0000F000, 32'h000000FF, 32'hFFFFFFFF, 32'hDEADBEEF, 32'd0};
    p0 = pulses32;
    for (int i = 0; i < 10; i++) begin
      v32 = 1'b1; c32 = cv[i]; a32 = av[i]; b32 = bv[i];
      tick();
      checks++;
      if (ov32 !== 1'b1 || rdy32 !== 1'b1 || r32 !== ev[i] || z32 !== (ev[i] == 32'd0)) begin
        failures++;
        $display("FAIL b2b[%0d] ctrl=%0d: ov=%b rdy=%b res=%h zero=%b, want 1 1 %h %b",
                 i, cv[i], ov32, rdy32, r32, z32, ev[i], (ev[i] == 32'd0));
      end
    end
    v32 = 1'b0;
    tick();
    checks++;
    if (ov32 !== 1'b0 || pulses32 - p0 !== 10) begin
      failures++;
      $display("FAIL b2b_count: ov=%b pulses=%0d, want 0 10", ov32, pulses32 - p0);
    end
  endtask

  task automatic test_mul();
    logic [31:0] res; logic zr; int lat, busy, p0;
    p0 = pulses32;
    run32(4'd3, 32'h00010001, 32'h00010001, res, zr, lat, busy);
    checks++;
    if (res !== 32'h00020001 || zr !== 1'b0) begin
      failures++;
      $display("FAIL mul_res: res=%h zero=%b, want 00020001 0", res, zr);
    end
    checks++;
    if (lat !== 33 || busy !== 32) begin
      failures++;
      $display("FAIL mul_timing: latency=%0d busy=%0d, want 33 32", lat, busy);
    end
    repeat (4) tick();
    checks++;
    if (pulses32 - p0 !== 1) begin
      failures++;
      $display("FAIL mul_extra_accept: pulses=%0d, want 1", pulses32 - p0);
    end
  endtask

  task automatic test_div();
    logic [3:0]  cv [4];
    logic [31:0] av [4], bv [4], ev [4];
    logic [31:0] res; logic zr; int lat, busy;
    cv = '{4'd4, 4'd5, 4'd4, 4'd5};
    av = '{32'd100, 32'd100, 32'd5, 32'd5};
    bv = '{32'd7, 32'd7, 32'd0, 32'd0};
    ev = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'd5};
    for (int i = 0; i < 4; i++) begin
      run32(cv[i], av[i], bv[i], res, zr, lat, busy);
      tick();
      checks++;
      if (res !== ev[i] || zr !== 1'b0 || lat !== 33) begin
        failures++;
        $display("FAIL div[%0d] ctrl=%0d %0d/%0d: res=%h zero=%b lat=%0d, want %h 0 33",
                 i, cv[i], av[i], bv[i], res, zr, lat, ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    v32 = 1'b1; c32 = 4'd4; a32 = 32'd100; b32 = 32'd7;
    tick();
    v32 = 1'b0;
    repeat (10) tick();
    p0 = pulses32;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rdy32 !== 1'b1 || ov32 !== 1'b0 || r32 !== 32'd0 || z32 !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: rdy=%b ov=%b res=%h zero=%b, want 1 0 0 1", rdy32, ov32, r32, z32);
    end
    tick();
    rst = 1'b0;
    repeat (40) tick();
    checks++;
    if (pulses32 !== p0) begin
      failures++;
      $display("FAIL reset_mid_pulse: pulses=%0d, want %0d", pulses32, p0);
    end
    v32 = 1'b1; c32 = 4'd2; a32 = 32'd1; b32 = 32'd1;
    tick();
    v32 = 1'b0;
    checks++;
    if (ov32 !== 1'b1 || r32 !== 32'd2 || z32 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_add: ov=%b res=%h zero=%b, want 1 2 0", ov32, r32, z32);
    end
    tick();
  endtask

  task automatic test_width8();
    int lat, busy;
    v8 = 1'b1; c8 = 4'd3; a8 = 8'h10; b8 = 8'h11;
    tick();
    v8 = 1'b0;
    lat = 999; busy = 0;
    for (int k = 0; k < 50; k++) begin
      if (ov8) begin lat = k + 1; break; end
      if (!rdy8) busy++;
      tick();
    end
    checks++;
    if (r8 !== 8'h10 || z8 !== 1'b0 || lat !== 9 || busy !== 8) begin
      failures++;
      $display("FAIL w8_mul: res=%h zero=%b lat=%0d busy=%0d, want 10 0 9 8", r8, z8, lat, busy);
    end
    tick();
    v8 = 1'b1; c8 = 4'd2; a8 = 8'hFF; b8 = 8'h01;
    tick();
    checks++;
    if (ov8 !== 1'b1 || r8 !== 8'h00 || z8 !== 1'b1) begin
      failures++;
      $display("FAIL w8_add_wrap: ov=%b res=%h zero=%b, want 1 00 1", ov8, r8, z8);
    end
    c8 = 4'd2; a8 = 8'h10; b8 = 8'h01;
    tick();
    checks++;
    if (ov8 !== 1'b1 || r8 !== 8'h11 || z8 !== 1'b0) begin
      failures++;
      $display("FAIL w8_add: ov=%b res=%h zero=%b, want 1 11 0", ov8, r8, z8);
    end
    c8 = 4'd15; a8 = 8'h5A; b8 = 8'hA5;
    tick();
    v8 = 1'b0;
    checks++;
    if (ov8 !== 1'b1 || r8 !== 8'h00 || z8 !== 1'b1) begin
      failures++;
      $display("FAIL w8_undef_ctrl: ov=%b res=%h zero=%b, want 1 00 1", ov8, r8, z8);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_div();
    test_reset_mid();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
